// File: rtl/tiny_aes_axi_pkg.sv
// Shared AXI4 burst types, response codes, FSM state encodings and the
// beat-to-beat address generator used by both channels of the burst memory.
package tiny_aes_axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Only the first beat may be unaligned; every later beat starts from the aligned address.
  function automatic logic [31:0] next_addr(
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [31:0] bytes;
    logic [31:0] span;
    logic [31:0] aligned;
    logic [31:0] boundary;
    logic [31:0] incr;
    bytes    = 32'd1 << size;
    aligned  = addr & ~(bytes - 32'd1);
    incr     = aligned + bytes;
    span     = (32'(len) + 32'd1) << size;
    boundary = addr & ~(span - 32'd1);
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = incr;
      WRAP:    next_addr = (incr == boundary + span) ? boundary : incr;
      default: next_addr = addr;
    endcase
  endfunction

  function automatic logic burst_illegal(
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst,
    input logic [2:0] maxSize
  );
    logic bad;
    bad = (size > maxSize) || (burst == 2'b11);
    if (burst == WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      bad = 1'b1;
    burst_illegal = bad;
  endfunction

endpackage

// File: rtl/tiny_aes_bram_1w1r.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A same-word read and write in one cycle returns the old contents.
module tiny_aes_bram_1w1r #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [AW-1:0]           i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tiny_aes_axi4_burst_mem.sv
// AXI4 burst slave backing the tiny_aes data window: independent read and
// write FSMs over a local word-addressed RAM, with FIXED/INCR/WRAP bursts.
module tiny_aes_axi4_burst_mem
  import tiny_aes_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam int         ADDR_LSB = $clog2(STRB_W);
  localparam int         IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int         RAM_AW   = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);

  wr_state_t             r_wState;
  logic                  r_awReady, r_wReady, r_bValid;
  logic [1:0]            r_bResp;
  logic [ID_WIDTH-1:0]   r_bId;
  logic [ADDR_WIDTH-1:0] r_wAddr;
  logic [7:0]            r_wLen, r_wCnt;
  logic [2:0]            r_wSize;
  logic [1:0]            r_wBurst;
  logic                  r_wErr, r_wBurstErr;

  rd_state_t             r_rState;
  logic                  r_arReady, r_rValid, r_rLast, r_rZero;
  logic [1:0]            r_rResp;
  logic [ID_WIDTH-1:0]   r_rId;
  logic [ADDR_WIDTH-1:0] r_rAddr;
  logic [7:0]            r_rLen, r_rCnt;
  logic [2:0]            r_rSize;
  logic [1:0]            r_rBurst;
  logic                  r_rBurstErr;

  logic                  w_wBeat, w_wOor, w_wLenBad, w_ramWe;
  logic [IDX_W-1:0]      w_wIdx;
  logic [ADDR_WIDTH-1:0] w_wNext;
  logic                  w_arHs, w_rHs, w_arBad, w_rdOor, w_rdErr, w_ramRe;
  logic [ADDR_WIDTH-1:0] w_rNext, w_rdAddr;
  logic [IDX_W-1:0]      w_rdIdx;
  logic [DATA_WIDTH-1:0] w_ramQ;

  assign w_wBeat   = (r_wState == W_DATA) && WVALID && r_wReady;
  assign w_wIdx    = r_wAddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_wOor    = {1'b0, w_wIdx} >= (IDX_W+1)'(DEPTH);
  assign w_wLenBad = WLAST != (r_wCnt == r_wLen);
  assign w_ramWe   = w_wBeat && !r_wBurstErr && !w_wOor;
  assign w_wNext   = ADDR_WIDTH'(next_addr(32'(r_wAddr), r_wLen, r_wSize, r_wBurst));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wState    <= W_IDLE;
      r_awReady   <= 1'b1;
      r_wReady    <= 1'b0;
      r_bValid    <= 1'b0;
      r_bResp     <= OKAY;
      r_bId       <= '0;
      r_wAddr     <= '0;
      r_wLen      <= '0;
      r_wCnt      <= '0;
      r_wSize     <= '0;
      r_wBurst    <= '0;
      r_wErr      <= 1'b0;
      r_wBurstErr <= 1'b0;
    end else begin
      case (r_wState)
        W_IDLE: begin
          if (AWVALID && r_awReady) begin
            r_bId       <= AWID;
            r_wAddr     <= AWADDR;
            r_wLen      <= AWLEN;
            r_wSize     <= AWSIZE;
            r_wBurst    <= AWBURST;
            r_wCnt      <= '0;
            r_wErr      <= burst_illegal(AWLEN, AWSIZE, AWBURST, MAX_SIZE);
            r_wBurstErr <= burst_illegal(AWLEN, AWSIZE, AWBURST, MAX_SIZE);
            r_awReady   <= 1'b0;
            r_wReady    <= 1'b1;
            r_wState    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wBeat) begin
            if (w_wOor || w_wLenBad) r_wErr <= 1'b1;
            // WLAST, not the beat count, terminates the burst.
            if (WLAST) begin
              r_wReady <= 1'b0;
              r_bValid <= 1'b1;
              r_bResp  <= (r_wErr || w_wOor || w_wLenBad) ? SLVERR : OKAY;
              r_wState <= W_RESP;
            end else begin
              r_wCnt  <= r_wCnt + 8'd1;
              r_wAddr <= w_wNext;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bValid  <= 1'b0;
            r_awReady <= 1'b1;
            r_wState  <= W_IDLE;
          end
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  // The RAM is addressed ahead of the handshake so the next beat is ready one edge later.
  assign w_arHs   = (r_rState == R_IDLE) && ARVALID && r_arReady;
  assign w_rHs    = (r_rState == R_DATA) && r_rValid && RREADY;
  assign w_arBad  = burst_illegal(ARLEN, ARSIZE, ARBURST, MAX_SIZE);
  assign w_rNext  = ADDR_WIDTH'(next_addr(32'(r_rAddr), r_rLen, r_rSize, r_rBurst));
  assign w_rdAddr = w_arHs ? ARADDR : w_rNext;
  assign w_rdIdx  = w_rdAddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_rdOor  = {1'b0, w_rdIdx} >= (IDX_W+1)'(DEPTH);
  assign w_rdErr  = (w_arHs ? w_arBad : r_rBurstErr) || w_rdOor;
  assign w_ramRe  = w_arHs || (w_rHs && !r_rLast);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rState    <= R_IDLE;
      r_arReady   <= 1'b1;
      r_rValid    <= 1'b0;
      r_rLast     <= 1'b0;
      r_rResp     <= OKAY;
      r_rId       <= '0;
      r_rZero     <= 1'b1;
      r_rAddr     <= '0;
      r_rLen      <= '0;
      r_rCnt      <= '0;
      r_rSize     <= '0;
      r_rBurst    <= '0;
      r_rBurstErr <= 1'b0;
    end else begin
      case (r_rState)
        R_IDLE: begin
          if (w_arHs) begin
            r_rId       <= ARID;
            r_rAddr     <= ARADDR;
            r_rLen      <= ARLEN;
            r_rSize     <= ARSIZE;
            r_rBurst    <= ARBURST;
            r_rBurstErr <= w_arBad;
            r_rCnt      <= '0;
            r_rValid    <= 1'b1;
            r_rLast     <= (ARLEN == 8'd0);
            r_rResp     <= w_rdErr ? SLVERR : OKAY;
            r_rZero     <= w_rdErr;
            r_arReady   <= 1'b0;
            r_rState    <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_rHs) begin
            if (r_rLast) begin
              r_rValid  <= 1'b0;
              r_rLast   <= 1'b0;
              r_arReady <= 1'b1;
              r_rState  <= R_IDLE;
            end else begin
              r_rAddr <= w_rNext;
              r_rCnt  <= r_rCnt + 8'd1;
              r_rLast <= (r_rCnt + 8'd1) == r_rLen;
              r_rResp <= w_rdErr ? SLVERR : OKAY;
              r_rZero <= w_rdErr;
            end
          end
        end
      endcase
    end
  end

  tiny_aes_bram_1w1r #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (RAM_AW)
  ) u_bram (
    .i_clk  (ACLK),
    .i_we   (w_ramWe),
    .i_waddr(w_wIdx[RAM_AW-1:0]),
    .i_wstrb(WSTRB),
    .i_wdata(WDATA),
    .i_re   (w_ramRe),
    .i_raddr(w_rdIdx[RAM_AW-1:0]),
    .o_rdata(w_ramQ)
  );

  assign AWREADY = r_awReady;
  assign WREADY  = r_wReady;
  assign BVALID  = r_bValid;
  assign BRESP   = r_bResp;
  assign BID     = r_bId;
  assign ARREADY = r_arReady;
  assign RVALID  = r_rValid;
  assign RLAST   = r_rLast;
  assign RRESP   = r_rResp;
  assign RID     = r_rId;
  assign RDATA   = r_rZero ? '0 : w_ramQ;

endmodule
